neuron_mac: RTL and testbench

//  Parametrised, pipelined signed multiply-accumulate for one neuron's dot product (sum of w[i]*x[i]).

---
 rtl/neuron_mac.sv | 111 +++++++++++
 tb/tb_neuron_mac.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// Pipelined signed multiply-accumulate for one neuron dot product, streamed under valid/ready.
// Build option MAC_SATURATE_EN: clamp the accumulator on signed overflow instead of wrapping.
module neuron_mac #(
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int ACC_W = 32,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam int P_W = A_W + B_W;
  localparam int EXT_W = ACC_W + 1 - P_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [P_W-1:0]   r_p;
  logic                    r_p_vld;
  logic                    r_p_last;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_ovf;
  logic                    r_out_valid;
  logic signed [ACC_W-1:0] r_out_sum;
  logic [CNT_W-1:0]        r_out_count;
  logic                    r_out_ovf;

  logic                    w_en;
  logic signed [ACC_W:0]   w_s;
  logic                    w_ovf;
  logic signed [ACC_W-1:0] w_next;
  logic [CNT_W-1:0]        w_cnt_inc;

  // A pending result that is not being taken freezes the whole pipeline.
  assign w_en      = ~r_out_valid | out_ready;
  assign in_ready  = w_en & ~rst;
  assign w_s       = {r_acc[ACC_W-1], r_acc} + {{EXT_W{r_p[P_W-1]}}, r_p};
  assign w_ovf     = w_s[ACC_W] ^ w_s[ACC_W-1];
  assign w_cnt_inc = r_cnt + CNT_ONE;

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

  // Next accumulator value: wrapped sum, or clamped and held once saturated.
  always_comb begin
    w_next = w_s[ACC_W-1:0];
`ifdef MAC_SATURATE_EN
    if (r_ovf) begin
      w_next = r_acc;
    end else if (w_ovf) begin
      w_next = w_s[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      w_next = w_s[ACC_W-1:0];
    end
`endif
  end

  // Multiply stage, accumulate stage and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p         <= '0;
      r_p_vld     <= 1'b0;
      r_p_last    <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_en) begin
      r_p      <= $signed(in_a) * $signed(in_b);
      r_p_vld  <= in_valid;
      r_p_last <= in_last & in_valid;
      // A last element retires the vector and clears state for the next one in the same edge.
      if (r_p_vld && r_p_last) begin
        r_out_valid <= 1'b1;
        r_out_sum   <= w_next;
        r_out_count <= w_cnt_inc;
        r_out_ovf   <= r_ovf | w_ovf;
        r_acc       <= '0;
        r_cnt       <= '0;
        r_ovf       <= 1'b0;
      end else if (r_p_vld) begin
        r_out_valid <= 1'b0;
        r_acc       <= w_next;
        r_cnt       <= w_cnt_inc;
        r_ovf       <= r_ovf | w_ovf;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else begin
      r_p_vld <= r_p_vld;
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac (ACC_W=16) with a result scoreboard queue.
module tb_neuron_mac;

  typedef struct packed {
    logic [15:0] sum;
    logic [9:0]  cnt;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [9:0]  out_count;
  logic        out_ovf;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  neuron_mac #(.A_W(8), .B_W(8), .ACC_W(16), .CNT_W(10)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int sum, input int cnt, input logic ovf);
    exp_t e;
    e.sum = sum[15:0];
    e.cnt = cnt[9:0];
    e.ovf = ovf;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one pair and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input int a, input int b, input logic last);
    int k;
    in_a = a[7:0];
    in_b = b[7:0];
    in_last = last;
    in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      k++;
      @(negedge clk);
    end
    if (k >= 50) begin
      n_cmp++;
      n_fail++;
      $error("FAIL send_timeout: observed in_ready=0 for %0d cycles expected 1", k);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  // Scoreboard: every completed handshake on the result port pops one expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $error("FAIL sb_unexpected: observed result %0d expected none", $signed(out_sum));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_sum", $signed(out_sum), $signed(e.sum));
        chk("sb_count", {22'd0, out_count}, {22'd0, e.cnt});
        chk("sb_ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
      end
    end
  end

  initial begin
    int acc_m;
    int s;
    int len;
    int av;
    int bv;
    logic o;
    logic ovf_m;
    logic signed [15:0] t16;

    rst = 1'b1;
    in_valid = 1'b0;
    in_a = 8'd0;
    in_b = 8'd0;
    in_last = 1'b0;
    out_ready = 1'b1;
    idle(3);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'sd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'sd0);
    chk("rst_out_sum", $signed(out_sum), 32'sd0);
    chk("rst_out_count", {22'd0, out_count}, 32'sd0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 32'sd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // Four element vector and two-cycle latency.
    push(70, 4, 1'b0);
    send(1, 5, 1'b0);
    send(2, 6, 1'b0);
    send(3, 7, 1'b0);
    send(4, 8, 1'b1);
    @(negedge clk);
    chk("lat_t1", {31'd0, out_valid}, 32'sd0);
    @(negedge clk);
    chk("lat_t2", {31'd0, out_valid}, 32'sd1);
    chk("lat_sum", $signed(out_sum), 32'sd70);
    @(negedge clk);
    chk("lat_t3", {31'd0, out_valid}, 32'sd0);
    idle(1);

    // Signed extremes.
    push(16257, 2, 1'b0);
    send(-128, -128, 1'b0);
    send(127, -1, 1'b1);
    idle(4);

    // Back-to-back single element vectors.
    push(9, 1, 1'b0);
    push(-10, 1, 1'b0);
    send(3, 3, 1'b1);
    send(-2, 5, 1'b1);
    @(negedge clk);
    chk("b2b_v1", {31'd0, out_valid}, 32'sd1);
    chk("b2b_s1", $signed(out_sum), 32'sd9);
    @(negedge clk);
    chk("b2b_v2", {31'd0, out_valid}, 32'sd1);
    chk("b2b_s2", $signed(out_sum), -32'sd10);
    idle(3);

    // Back-pressure while a result is pending.
    out_ready = 1'b0;
    push(16, 1, 1'b0);
    send(4, 4, 1'b1);
    idle(2);
    in_a = 8'd1;
    in_b = 8'd1;
    in_last = 1'b0;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready}, 32'sd0);
      chk("stall_valid", {31'd0, out_valid}, 32'sd1);
      chk("stall_sum", $signed(out_sum), 32'sd16);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(14, 3, 1'b0);
    send(1, 1, 1'b0);
    send(2, 2, 1'b0);
    send(3, 3, 1'b1);
    idle(4);

    // Overflow of a 16-bit accumulator.
`ifdef MAC_SATURATE_EN
    push(32767, 3, 1'b1);
`else
    push(-17149, 3, 1'b1);
`endif
    send(127, 127, 1'b0);
    send(127, 127, 1'b0);
    send(127, 127, 1'b1);
    idle(4);

    // Random vectors against an integer reference model.
    repeat (6) begin
      len = int'($urandom_range(1, 6));
      acc_m = 0;
      ovf_m = 1'b0;
      for (int i = 0; i < len; i++) begin
        av = int'($urandom_range(0, 255)) - 128;
        bv = int'($urandom_range(0, 255)) - 128;
        s = acc_m + av * bv;
        o = (s > 32767) || (s < -32768);
`ifdef MAC_SATURATE_EN
        if (ovf_m) s = acc_m;
        else if (o) s = (s > 0) ? 32767 : -32768;
`else
        t16 = s[15:0];
        s = int'(t16);
`endif
        ovf_m = ovf_m | o;
        acc_m = s;
        if (i == len - 1) push(acc_m, len, ovf_m);
        send(av, bv, i == len - 1);
      end
    end
    idle(4);

    // Element counter wraps modulo 2**CNT_W.
    push(1025, 1, 1'b0);
    for (int i = 0; i < 1025; i++) send(1, 1, i == 1024);
    idle(4);

    // Reset mid-vector discards the partial sum.
    send(5, 5, 1'b0);
    send(6, 6, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'sd0);
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'sd0);
    chk("mid_rst_sum", $signed(out_sum), 32'sd0);
    chk("mid_rst_count", {22'd0, out_count}, 32'sd0);
    chk("mid_rst_ovf", {31'd0, out_ovf}, 32'sd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(4, 1, 1'b0);
    send(2, 2, 1'b1);
    idle(5);

    chk("sb_drained", q.size(), 32'sd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
